// File: rtl/riscv_soft_bypass_ctrl_pkg.sv
// Shared defaults and ALU source-select codes for the EX-stage operand bypass.
// Optional build macro: RISCV_SOFT_BYPASS_PERF_EN (performance counters).
package riscv_soft_bypass_ctrl_pkg;

   localparam int XPR_LEN_DEFAULT    = 32;
   localparam int REG_ADDR_W_DEFAULT = 5;

   localparam logic [1:0] ALU_SRC_RS  = 2'd0;
   localparam logic [1:0] ALU_SRC_PC  = 2'd1;
   localparam logic [1:0] ALU_SRC_IMM = 2'd2;
   localparam logic [1:0] ALU_SRC_FWD = 2'd3;

endpackage

// File: rtl/riscv_soft_bypass_ctrl_if.sv
// Datapath <-> bypass controller signal bundle; slave = bypass controller side.
// Perf counter signals exist only with RISCV_SOFT_BYPASS_PERF_EN.
interface riscv_soft_bypass_ctrl_if #(
   parameter int XPR_LEN    = 32,
   parameter int REG_ADDR_W = 5
);
   // No valid/ready pair here: ex_valid qualifies the EX slot every cycle and
   // stall_out is a same-cycle request that the datapath must honour.
   logic                  pipe_stall;
   logic                  ex_valid;
   logic                  ex_wen;
   logic                  ex_is_load;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic [XPR_LEN-1:0]    ex_result;
   logic [REG_ADDR_W-1:0] ex_rs1;
   logic [REG_ADDR_W-1:0] ex_rs2;
   logic                  ex_rs1_used;
   logic                  ex_rs2_used;
   logic [XPR_LEN-1:0]    mem_rdata;
   logic                  fwd_a;
   logic                  fwd_b;
   logic [XPR_LEN-1:0]    bypass_data_a;
   logic [XPR_LEN-1:0]    bypass_data_b;
   logic                  stall_out;
`ifdef RISCV_SOFT_BYPASS_PERF_EN
   logic [31:0]           perf_fwd_cnt;
   logic [31:0]           perf_luse_cnt;
`endif

   modport master (
      output pipe_stall, ex_valid, ex_wen, ex_is_load, ex_rd, ex_result,
             ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, mem_rdata,
      input  fwd_a, fwd_b, bypass_data_a, bypass_data_b, stall_out
`ifdef RISCV_SOFT_BYPASS_PERF_EN
      , input perf_fwd_cnt, perf_luse_cnt
`endif
   );

   modport slave (
      input  pipe_stall, ex_valid, ex_wen, ex_is_load, ex_rd, ex_result,
             ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, mem_rdata,
      output fwd_a, fwd_b, bypass_data_a, bypass_data_b, stall_out
`ifdef RISCV_SOFT_BYPASS_PERF_EN
      , output perf_fwd_cnt, perf_luse_cnt
`endif
   );

endinterface

// File: rtl/riscv_soft_bypass_match.sv
// One operand's slot match: MEM beats WB, and a load in MEM blocks forwarding
// and raises a load-use request instead.
module riscv_soft_bypass_match
   import riscv_soft_bypass_ctrl_pkg::*;
#(
   parameter int XPR_LEN    = XPR_LEN_DEFAULT,
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  src_used,
   input  logic                  m_v,
   input  logic [REG_ADDR_W-1:0] m_rd,
   input  logic                  m_is_load,
   input  logic [XPR_LEN-1:0]    m_result,
   input  logic                  w_v,
   input  logic [REG_ADDR_W-1:0] w_rd,
   input  logic [XPR_LEN-1:0]    w_data,
   output logic                  fwd,
   output logic [XPR_LEN-1:0]    data,
   output logic                  luse
);

   logic hit_m;
   logic hit_w;

   assign hit_m = m_v & (m_rd == src) & src_used;
   assign hit_w = w_v & (w_rd == src) & src_used;

   always_comb begin
      fwd  = 1'b0;
      data = '0;
      luse = 1'b0;
      if (hit_m) begin
         // An older W copy of the same register is stale; wait for the load.
         if (m_is_load) begin
            luse = 1'b1;
         end else begin
            fwd  = 1'b1;
            data = m_result;
         end
      end else if (hit_w) begin
         fwd  = 1'b1;
         data = w_data;
      end
   end

endmodule

// File: rtl/riscv_soft_bypass_ctrl.sv
// EX-stage operand bypass producer: tracks MEM/WB writes, drives forwarding
// selects and load-use stalls. Optional counters: RISCV_SOFT_BYPASS_PERF_EN.
module riscv_soft_bypass_ctrl
   import riscv_soft_bypass_ctrl_pkg::*;
#(
   parameter int XPR_LEN    = XPR_LEN_DEFAULT,
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset_n,
   riscv_soft_bypass_ctrl_if.slave bus
);

   logic                  m_v;
   logic [REG_ADDR_W-1:0] m_rd;
   logic                  m_is_load;
   logic [XPR_LEN-1:0]    m_result;
   logic                  w_v;
   logic [REG_ADDR_W-1:0] w_rd;
   logic [XPR_LEN-1:0]    w_data;

   logic                  ex_track;
   logic                  luse_a;
   logic                  luse_b;
   logic                  stall_out;

   // x0 writes are never tracked so a reader of x0 can never match.
   assign ex_track  = bus.ex_valid & bus.ex_wen & (bus.ex_rd != '0);
   assign stall_out = luse_a | luse_b;
   assign bus.stall_out = stall_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_v       <= 1'b0;
         m_rd      <= '0;
         m_is_load <= 1'b0;
         m_result  <= '0;
         w_v       <= 1'b0;
         w_rd      <= '0;
         w_data    <= '0;
      end else if (!bus.pipe_stall) begin
         w_v    <= m_v;
         w_rd   <= m_rd;
         w_data <= m_is_load ? bus.mem_rdata : m_result;
         if (stall_out) begin
            m_v <= 1'b0;
         end else begin
            m_v       <= ex_track;
            m_rd      <= bus.ex_rd;
            m_is_load <= bus.ex_is_load;
            m_result  <= bus.ex_result;
         end
      end
   end

   riscv_soft_bypass_match #(.XPR_LEN(XPR_LEN), .REG_ADDR_W(REG_ADDR_W)) u_match_a (
      .src       (bus.ex_rs1),
      .src_used  (bus.ex_rs1_used),
      .m_v       (m_v),
      .m_rd      (m_rd),
      .m_is_load (m_is_load),
      .m_result  (m_result),
      .w_v       (w_v),
      .w_rd      (w_rd),
      .w_data    (w_data),
      .fwd       (bus.fwd_a),
      .data      (bus.bypass_data_a),
      .luse      (luse_a)
   );

   riscv_soft_bypass_match #(.XPR_LEN(XPR_LEN), .REG_ADDR_W(REG_ADDR_W)) u_match_b (
      .src       (bus.ex_rs2),
      .src_used  (bus.ex_rs2_used),
      .m_v       (m_v),
      .m_rd      (m_rd),
      .m_is_load (m_is_load),
      .m_result  (m_result),
      .w_v       (w_v),
      .w_rd      (w_rd),
      .w_data    (w_data),
      .fwd       (bus.fwd_b),
      .data      (bus.bypass_data_b),
      .luse      (luse_b)
   );

`ifdef RISCV_SOFT_BYPASS_PERF_EN
   logic [31:0] perf_fwd_cnt;
   logic [31:0] perf_luse_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fwd_cnt  <= '0;
         perf_luse_cnt <= '0;
      end else if (!bus.pipe_stall) begin
         perf_fwd_cnt  <= perf_fwd_cnt + {31'd0, bus.fwd_a | bus.fwd_b};
         perf_luse_cnt <= perf_luse_cnt + {31'd0, stall_out};
      end
   end

   assign bus.perf_fwd_cnt  = perf_fwd_cnt;
   assign bus.perf_luse_cnt = perf_luse_cnt;
`endif

endmodule

// File: tb/tb_riscv_soft_bypass_ctrl.sv
// Table-driven bench for riscv_soft_bypass_ctrl plus hand-written reset sequence.
// Counter checks compile in with RISCV_SOFT_BYPASS_PERF_EN.
module tb_riscv_soft_bypass_ctrl;

   localparam int NV = 21;

   typedef struct {
      logic        ps, v, wen, ld;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic [31:0] rdata;
      logic        efa, efb;
      logic [31:0] eda, edb;
      logic        est;
   } vec_t;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_pass;
   vec_t tbl [NV];

   riscv_soft_bypass_ctrl_if #(.XPR_LEN(32), .REG_ADDR_W(5)) bus ();

   riscv_soft_bypass_ctrl #(.XPR_LEN(32), .REG_ADDR_W(5)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic ps, v, wen, ld, input logic [4:0] rd,
                               input logic [31:0] res, input logic [4:0] rs1,
                               input logic u1, input logic [4:0] rs2, input logic u2,
                               input logic [31:0] rdata, input logic efa, efb,
                               input logic [31:0] eda, edb, input logic est);
      vec_t t;
      t.ps = ps; t.v = v; t.wen = wen; t.ld = ld; t.rd = rd; t.res = res;
      t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rdata = rdata;
      t.efa = efa; t.efb = efb; t.eda = eda; t.edb = edb; t.est = est;
      return t;
   endfunction

   // driver tasks
   task automatic drive(input vec_t t);
      bus.pipe_stall  = t.ps;
      bus.ex_valid    = t.v;
      bus.ex_wen      = t.wen;
      bus.ex_is_load  = t.ld;
      bus.ex_rd       = t.rd;
      bus.ex_result   = t.res;
      bus.ex_rs1      = t.rs1;
      bus.ex_rs1_used = t.u1;
      bus.ex_rs2      = t.rs2;
      bus.ex_rs2_used = t.u2;
      bus.mem_rdata   = t.rdata;
   endtask

   // scoreboard
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic chk_outs(input string tag, input vec_t t);
      chk({tag, " fwd_a"}, {31'd0, bus.fwd_a}, {31'd0, t.efa});
      chk({tag, " fwd_b"}, {31'd0, bus.fwd_b}, {31'd0, t.efb});
      chk({tag, " data_a"}, bus.bypass_data_a, t.eda);
      chk({tag, " data_b"}, bus.bypass_data_b, t.edb);
      chk({tag, " stall"}, {31'd0, bus.stall_out}, {31'd0, t.est});
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;

      //            ps v  wen ld rd  res       rs1 u1 rs2 u2 rdata      efa efb eda       edb       est
      tbl[0]  = mk(0, 1, 1, 0, 5,  'h11,     0,  0, 0,  0, 0,         0, 0, 0,        0,        0);
      tbl[1]  = mk(0, 1, 0, 0, 0,  0,        5,  1, 0,  0, 0,         1, 0, 'h11,     0,        0);
      tbl[2]  = mk(0, 1, 0, 0, 0,  0,        5,  1, 0,  0, 0,         1, 0, 'h11,     0,        0);
      tbl[3]  = mk(0, 1, 1, 1, 7,  'h1234,   0,  0, 0,  0, 0,         0, 0, 0,        0,        0);
      tbl[4]  = mk(0, 1, 1, 0, 9,  'h55,     0,  0, 7,  1, 'hCAFE,    0, 0, 0,        0,        1);
      tbl[5]  = mk(0, 1, 1, 0, 9,  'h55,     0,  0, 7,  1, 0,         0, 1, 0,        'hCAFE,   0);
      tbl[6]  = mk(0, 1, 1, 0, 3,  1,        9,  1, 0,  0, 0,         1, 0, 'h55,     0,        0);
      tbl[7]  = mk(0, 1, 1, 0, 3,  2,        0,  0, 9,  1, 0,         0, 1, 0,        'h55,     0);
      tbl[8]  = mk(0, 0, 0, 0, 0,  0,        3,  1, 3,  1, 0,         1, 1, 2,        2,        0);
      tbl[9]  = mk(0, 1, 1, 0, 0,  'h99,     3,  0, 3,  1, 0,         0, 1, 0,        2,        0);
      tbl[10] = mk(0, 0, 1, 0, 4,  'h44,     0,  1, 0,  1, 0,         0, 0, 0,        0,        0);
      tbl[11] = mk(0, 1, 1, 0, 6,  'h66,     4,  1, 0,  0, 0,         0, 0, 0,        0,        0);
      tbl[12] = mk(1, 1, 1, 0, 8,  'h88,     6,  1, 0,  0, 0,         1, 0, 'h66,     0,        0);
      tbl[13] = mk(1, 1, 1, 0, 8,  'h88,     6,  1, 0,  0, 0,         1, 0, 'h66,     0,        0);
      tbl[14] = mk(1, 1, 1, 0, 8,  'h88,     6,  1, 0,  0, 0,         1, 0, 'h66,     0,        0);
      tbl[15] = mk(0, 1, 1, 0, 8,  'h88,     6,  1, 0,  0, 0,         1, 0, 'h66,     0,        0);
      tbl[16] = mk(0, 0, 0, 0, 0,  0,        6,  1, 8,  1, 0,         1, 1, 'h66,     'h88,     0);
      tbl[17] = mk(0, 1, 1, 1, 10, 0,        8,  1, 0,  0, 0,         1, 0, 'h88,     0,        0);
      tbl[18] = mk(1, 0, 0, 0, 0,  0,        10, 1, 10, 1, 'hBEEF,    0, 0, 0,        0,        1);
      tbl[19] = mk(0, 0, 0, 0, 0,  0,        10, 1, 10, 1, 'hBEEF,    0, 0, 0,        0,        1);
      tbl[20] = mk(0, 0, 0, 0, 0,  0,        10, 1, 10, 1, 0,         1, 1, 'hBEEF,   'hBEEF,   0);

      // reset state, with a reader of r5 active
      reset_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef RISCV_SOFT_BYPASS_PERF_EN
      chk("reset perf_fwd", bus.perf_fwd_cnt, 32'd0);
      chk("reset perf_luse", bus.perf_luse_cnt, 32'd0);
`endif
      reset_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         chk_outs($sformatf("v%0d", i), tbl[i]);
         @(posedge clk);
         #1;
      end

      // fill M with r13 and W with r12, then reset asynchronously mid-cycle
      drive(mk(0, 1, 1, 0, 12, 'h12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      drive(mk(0, 1, 1, 0, 13, 'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      drive(mk(0, 0, 0, 0, 0, 0, 13, 1, 12, 1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk_outs("pre_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h13, 'h12, 0));
`ifdef RISCV_SOFT_BYPASS_PERF_EN
      chk("perf_fwd", bus.perf_fwd_cnt, 32'd11);
      chk("perf_luse", bus.perf_luse_cnt, 32'd2);
`endif
      #2;
      reset_n = 1'b0;
      #1;
      chk_outs("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef RISCV_SOFT_BYPASS_PERF_EN
      chk("rst perf_fwd", bus.perf_fwd_cnt, 32'd0);
      chk("rst perf_luse", bus.perf_luse_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk_outs("post_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // final report
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
